// File: rtl/alu_flag_cond_unit.sv
// Flag register and condition evaluator between the main decoder and the
// datapath. The flags come from the ALU and are held in a register. The
// instruction's condition field is tested against that registered copy, and
// the decoder's write and PC requests are passed on only when the test passes.
module alu_flag_cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000  // {V,C,Z,N}
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] alu_flags_i,
  input  logic       valid_i,
  input  logic       stall_i,
  input  logic [3:0] cond_i,
  input  logic [1:0] flag_write_i,
  input  logic       reg_write_i,
  input  logic       mem_write_i,
  input  logic       pc_src_i,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       pc_src_o,
  output logic       cond_ex_o,
  output logic       undef_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_true;
  logic       cond_ex;
  logic       flag_update;

  assign flag_v = flags_q[3];
  assign flag_c = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_n = flags_q[0];

  // Condition decode uses only the registered flags. Same-cycle ALU results
  // are not forwarded, so a compare affects the next instruction onward.
  always_comb begin
    cond_true = 1'b0;
    case (cond_i)
      4'b0000: cond_true = flag_z;                          // EQ
      4'b0001: cond_true = ~flag_z;                         // NE
      4'b0010: cond_true = flag_c;                          // CS
      4'b0011: cond_true = ~flag_c;                         // CC
      4'b0100: cond_true = flag_n;                          // MI
      4'b0101: cond_true = ~flag_n;                         // PL
      4'b0110: cond_true = flag_v;                          // VS
      4'b0111: cond_true = ~flag_v;                         // VC
      4'b1000: cond_true = flag_c & ~flag_z;                // HI
      4'b1001: cond_true = ~flag_c | flag_z;                // LS
      4'b1010: cond_true = (flag_n == flag_v);              // GE
      4'b1011: cond_true = (flag_n != flag_v);              // LT
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);    // GT
      4'b1101: cond_true = flag_z | (flag_n != flag_v);     // LE
      4'b1110: cond_true = 1'b1;                            // AL
      default: cond_true = 1'b0;                            // 1111 undefined
    endcase
  end

  // Including rst_n_i forces every gated output low while reset is held,
  // without waiting for a clock edge.
  assign cond_ex     = rst_n_i & valid_i & cond_true;
  assign cond_ex_o   = cond_ex;
  assign undef_o     = rst_n_i & valid_i & (cond_i == 4'b1111);
  assign reg_write_o = reg_write_i & cond_ex;
  assign mem_write_o = mem_write_i & cond_ex;
  assign pc_src_o    = pc_src_i & cond_ex;

  // A stall blocks only the flag update. Gated outputs above still follow
  // the condition, because the downstream stall suppresses the writes.
  assign flag_update = cond_ex & ~stall_i;

  // Flag register. The N/Z group and the C/V group are written independently.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flags_q <= RESET_FLAGS;
    end else if (flag_update) begin
      if (flag_write_i[1]) begin
        flags_q[1] <= alu_flags_i[1];
        flags_q[0] <= alu_flags_i[0];
      end
      if (flag_write_i[0]) begin
        flags_q[3] <= alu_flags_i[3];
        flags_q[2] <= alu_flags_i[2];
      end
    end
  end

  assign flags_o = flags_q;

endmodule

// File: tb/tb_alu_flag_cond_unit.sv
// Scoreboard bench for alu_flag_cond_unit. The stimulus thread drives
// directed vectors and queues the hand-computed response for each one. The
// monitor pops that response and compares it with the DUT outputs on the
// falling edge, or at once when an off-edge check is requested.
module tb_alu_flag_cond_unit;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [3:0] alu_flags_i = '0;
  logic       valid_i = 1'b0;
  logic       stall_i = 1'b0;
  logic [3:0] cond_i = '0;
  logic [1:0] flag_write_i = '0;
  logic       reg_write_i = 1'b0;
  logic       mem_write_i = 1'b0;
  logic       pc_src_i = 1'b0;
  logic       reg_write_o, mem_write_o, pc_src_o, cond_ex_o, undef_o;
  logic [3:0] flags_o;

  alu_flag_cond_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .alu_flags_i(alu_flags_i),
    .valid_i(valid_i), .stall_i(stall_i), .cond_i(cond_i),
    .flag_write_i(flag_write_i), .reg_write_i(reg_write_i),
    .mem_write_i(mem_write_i), .pc_src_i(pc_src_i),
    .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
    .pc_src_o(pc_src_o), .cond_ex_o(cond_ex_o), .undef_o(undef_o),
    .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected word: {reg_write, mem_write, pc_src, cond_ex, undef, flags[3:0]}
  logic [8:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;
  event       chk_ev;

  // Monitor: consume every queued expectation and compare it with the outputs
  always begin
    @(negedge clk_i or chk_ev);
    while (exp_q.size() > 0) begin
      logic [8:0] exp_w, act_w;
      string      nm;
      exp_w = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_w = {reg_write_o, mem_write_o, pc_src_o, cond_ex_o, undef_o, flags_o};
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL %s: got rw/mw/pc/cex/und=%b flags=%b, expected rw/mw/pc/cex/und=%b flags=%b",
                 nm, act_w[8:4], act_w[3:0], exp_w[8:4], exp_w[3:0]);
      end
    end
  end

  task automatic drive(input logic v, input logic st, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] alu,
                       input logic rw, input logic mw, input logic pc);
    valid_i = v; stall_i = st; cond_i = c; flag_write_i = fw;
    alu_flags_i = alu; reg_write_i = rw; mem_write_i = mw; pc_src_i = pc;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] eo, input logic [3:0] ef);
    exp_q.push_back({eo, ef});
    name_q.push_back(nm);
  endtask

  // One instruction per cycle: inputs change just after the rising edge.
  task automatic step(input string nm, input logic v, input logic st,
                      input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                      input logic rw, input logic mw, input logic pc,
                      input logic [4:0] eo, input logic [3:0] ef);
    @(posedge clk_i);
    #1;
    drive(v, st, c, fw, alu, rw, mw, pc);
    expect_out(nm, eo, ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // During reset, everything gated is low even with an AL instruction present
    drive(1, 0, 4'hE, 2'b00, 4'h0, 1, 1, 1);
    #2;
    expect_out("in_reset", 5'b00000, 4'b0000);
    -> chk_ev;
    #1;
    drive(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_n_i = 1'b1;

    //    name          v  st cond   fw     alu    rw mw pc  rw,mw,pc,cex,und  flags
    step("rst_eq",     1, 0, 4'h0, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b0000);
    step("al_set",     1, 0, 4'hE, 2'b11, 4'h2, 0, 0, 0, 5'b00010, 4'b0000);
    step("eq_mem",     1, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 5'b01010, 4'b0010);
    step("ne_mem",     1, 0, 4'h1, 2'b00, 4'h0, 0, 1, 0, 5'b00000, 4'b0010);
    step("set_all",    1, 0, 4'hE, 2'b11, 4'hF, 0, 0, 0, 5'b00010, 4'b0010);
    step("partial",    1, 0, 4'hE, 2'b10, 4'h0, 0, 0, 0, 5'b00010, 4'b1111);
    // flags {V,C,Z,N} = 1100
    step("idle_undef", 0, 0, 4'hF, 2'b11, 4'hF, 1, 1, 1, 5'b00000, 4'b1100);
    step("hi",         1, 0, 4'h8, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b1100);
    step("ls",         1, 0, 4'h9, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b1100);
    step("cs",         1, 0, 4'h2, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b1100);
    step("cc",         1, 0, 4'h3, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b1100);
    step("vs",         1, 0, 4'h6, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b1100);
    step("vc",         1, 0, 4'h7, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b1100);
    step("mi",         1, 0, 4'h4, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b1100);
    step("pl",         1, 0, 4'h5, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b1100);
    step("eq_false",   1, 0, 4'h0, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b1100);
    step("ne_true",    1, 0, 4'h1, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b1100);
    step("clear",      1, 0, 4'hE, 2'b11, 4'h0, 0, 0, 0, 5'b00010, 4'b1100);
    step("fail_cond",  1, 0, 4'h0, 2'b11, 4'hF, 1, 1, 1, 5'b00000, 4'b0000);
    step("fail_hold",  0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 5'b00000, 4'b0000);
    step("set_nv",     1, 0, 4'hE, 2'b11, 4'h9, 0, 0, 0, 5'b00010, 4'b0000);
    // flags = 1001: N=1, V=1
    step("ge",         1, 0, 4'hA, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b1001);
    step("lt",         1, 0, 4'hB, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b1001);
    step("gt",         1, 0, 4'hC, 2'b00, 4'h0, 0, 0, 1, 5'b00110, 4'b1001);
    step("le",         1, 0, 4'hD, 2'b00, 4'h0, 0, 0, 1, 5'b00000, 4'b1001);
    step("set_n",      1, 0, 4'hE, 2'b11, 4'h1, 0, 0, 0, 5'b00010, 4'b1001);
    // flags = 0001: N=1, V=0
    step("ge_n",       1, 0, 4'hA, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b0001);
    step("lt_n",       1, 0, 4'hB, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b0001);
    step("gt_n",       1, 0, 4'hC, 2'b00, 4'h0, 1, 0, 0, 5'b00000, 4'b0001);
    step("le_n",       1, 0, 4'hD, 2'b00, 4'h0, 1, 0, 0, 5'b10010, 4'b0001);
    step("stall",      1, 1, 4'hE, 2'b11, 4'h5, 1, 0, 0, 5'b10010, 4'b0001);
    step("stall_hold", 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 5'b00000, 4'b0001);
    step("undef",      1, 0, 4'hF, 2'b11, 4'hF, 1, 1, 1, 5'b00001, 4'b0001);
    step("fw01",       1, 0, 4'hE, 2'b01, 4'hA, 0, 0, 0, 5'b00010, 4'b0001);
    step("fw00",       1, 0, 4'hE, 2'b00, 4'hF, 0, 0, 0, 5'b00010, 4'b1001);
    step("pre_rst",    1, 0, 4'hE, 2'b11, 4'h6, 0, 0, 0, 5'b00010, 4'b1001);

    // Reset drops mid-cycle while an AL flag write is still pending
    @(negedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    expect_out("mid_rst", 5'b00000, 4'b0000);
    -> chk_ev;
    @(posedge clk_i);
    #2;
    drive(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    #1 rst_n_i = 1'b1;
    step("post_rst",   0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 5'b00000, 4'b0000);

    // Let the monitor drain the queue, within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_flag_cond_unit.md
Name: alu_flag_cond_unit

Overview:
- Consumer side of the ALU flag interface. It holds the architectural flag register, which it loads from the ALU's 4-bit flag vector.
- It evaluates the 4-bit condition field of the current instruction against the stored flags. It then gates the decoder's register-write, memory-write and PC-source requests.
- Sits between the main decoder and the datapath. The ALU drives it; the register file, data memory and PC mux read from it.

Parameters:
- RESET_FLAGS, 4'b0000, flag register value after reset. Bit order is {V,C,Z,N}.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- alu_flags_i  input  4  ALU flags: [3]=V overflow, [2]=C carry, [1]=Z zero, [0]=N negative.
- valid_i  input  1  an instruction is present this cycle.
- stall_i  input  1  pipeline hold; blocks flag update.
- cond_i  input  4  instruction condition field.
- flag_write_i  input  2  [1] updates N,Z; [0] updates C,V.
- reg_write_i  input  1  decoder register-write request.
- mem_write_i  input  1  decoder memory-write request.
- pc_src_i  input  1  decoder branch/PC-write request.
- reg_write_o  output  1  gated register write.
- mem_write_o  output  1  gated memory write.
- pc_src_o  output  1  gated PC source select.
- cond_ex_o  output  1  condition passed.
- undef_o  output  1  cond_i = 4'b1111 with valid_i high.
- flags_o  output  4  current flag register, {V,C,Z,N}.

Behaviour:
- Flag register:
  - 4 flops, asynchronously set to RESET_FLAGS when rst_n_i=0.
  - flags_o is driven directly from the register.
- Condition evaluation is combinational on cond_i and the registered flags, never on alu_flags_i:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0, with undef_o=1
- cond_ex_o = valid_i & condition_true.
- Output gating (zero latency):
  - reg_write_o = reg_write_i & cond_ex_o
  - mem_write_o = mem_write_i & cond_ex_o
  - pc_src_o = pc_src_i & cond_ex_o
- Outputs during reset:
  - While rst_n_i=0, every gated output, cond_ex_o and undef_o are forced to 0.
  - flags_o reads RESET_FLAGS while rst_n_i=0.
- Flag update happens on the rising edge when valid_i & cond_ex_o & ~stall_i:
  - flag_write_i[1]=1: N <= alu_flags_i[0], Z <= alu_flags_i[1].
  - flag_write_i[0]=1: C <= alu_flags_i[2], V <= alu_flags_i[3].
  - Groups not selected hold their value. flag_write_i=00 changes nothing.
- Failed condition: no flag update, all gated outputs 0, even when flag_write_i is nonzero.
- Ordering:
  - Same-cycle flag setting and condition use is not forwarded. The instruction in cycle t sees the flags written by instructions up to cycle t-1.
  - Back-to-back compare then conditional works with 1-cycle latency.
- stall_i=1:
  - The flag register holds.
  - Gated outputs still follow the combinational rules; the downstream stall owns write suppression.
- valid_i=0: all gated outputs and cond_ex_o are 0, no update, and undef_o=0.
- Reset asserted mid-stream: flags return to RESET_FLAGS immediately (asynchronous). Any update pending for that edge is discarded.

Test Plan:
- Reset with RESET_FLAGS=0000, then valid_i=1, cond_i=0000 (EQ), reg_write_i=1 -> cond_ex_o=0, reg_write_o=0, flags_o=0000.
- Cycle 1: cond_i=1110, flag_write_i=11, alu_flags_i=4'b0010. Cycle 2: cond_i=0000, mem_write_i=1 -> flags_o=0010 in cycle 2, mem_write_o=1. Cycle 2 with cond_i=0001 instead -> mem_write_o=0.
- Partial write:
  - Set flags to 1111.
  - Then cond_i=1110, flag_write_i=10, alu_flags_i=0000 -> flags_o=1100 (C,V kept; N,Z cleared).
- Failed condition:
  - flags=0000, cond_i=0000, flag_write_i=11, alu_flags_i=1111 -> no update, flags_o stays 0000.
  - pc_src_i=1 -> pc_src_o=0.
- Signed compares with flags {V,C,Z,N}=1001 (N=1, V=1):
  - GE (1010) -> 1, LT -> 0, GT -> 1, LE -> 0.
  - With 0001 (N=1, V=0): GE -> 0, LT -> 1.
- Stall and undefined condition:
  - stall_i=1 with cond_i=1110, flag_write_i=11, alu_flags_i=0101 -> flags unchanged.
  - cond_i=1111 -> undef_o=1, cond_ex_o=0.
  - Drop rst_n_i mid-cycle -> flags_o=RESET_FLAGS before the next edge.
